// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state behaviour).
package instr_loader_pkg;

   localparam int          IM_DEPTH_DEF  = 32;
   localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CSUM,
      FILL,
      RUN,
      ERROR
   } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
// master = host/boot side and memory, slave = loader.
interface instr_loader_if #(
   parameter int ADDR_W = 5
) ();

   logic [7:0]        byte_i;
   logic              byte_valid_i;
   logic              byte_ready_o;
   logic              im_we_o;
   logic [ADDR_W-1:0] im_addr_o;
   logic [31:0]       im_data_o;

   modport master (
      output byte_i, byte_valid_i,
      input  byte_ready_o, im_we_o, im_addr_o, im_data_o
   );

   modport slave (
      input  byte_i, byte_valid_i,
      output byte_ready_o, im_we_o, im_addr_o, im_data_o
   );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes MSB-first into 32-bit words and pulses word_valid
// the cycle after the 4th byte. Running XOR exists only with LOADER_CHECKSUM_EN.
module instr_loader_byte_packer
   import instr_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  csum
`endif
);

   logic [1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk_i) begin
      if (!rst_i || clear) begin
         cnt        <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= accept && (cnt == 2'd3);
         if (accept) begin
            word <= {word[23:0], byte_in};
            cnt  <= cnt + 2'd1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i || clear) begin
         csum <= '0;
      end else if (accept) begin
         csum <= csum ^ byte_in;
      end
   end
`endif

endmodule

// File: rtl/instr_loader.sv
// Streams a byte image into instruction memory, pads with the halt word and
// releases the CPU from reset. Optional feature macro: LOADER_CHECKSUM_EN.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int          IM_DEPTH  = IM_DEPTH_DEF,
   parameter int          ADDR_W    = 5,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_start_i,
   instr_loader_if.slave     bus,
   output logic              cpu_rst_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W:0]   word_count_o
);

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IM_DEPTH - 1);
   localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(IM_DEPTH);

   state_t            state, next_state;
   logic [ADDR_W-1:0] addr, addr_next;
   logic [ADDR_W:0]   count, count_next;
   logic              cpu_rst_n;
   logic              start, ready, load_accept, we;
   logic [31:0]       data;
   logic [31:0]       word;
   logic              word_valid;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   instr_loader_byte_packer u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (start),
      .accept     (load_accept),
      .byte_in    (bus.byte_i),
      .word       (word),
      .word_valid (word_valid)
`ifdef LOADER_CHECKSUM_EN
      ,
      .csum       (csum)
`endif
   );

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      next_state  = state;
      addr_next   = addr;
      count_next  = count;
      start       = 1'b0;
      ready       = 1'b0;
      load_accept = 1'b0;
      we          = 1'b0;
      data        = '0;
      case (state)
         IDLE, RUN, ERROR: begin
            if (load_start_i) begin
               start      = 1'b1;
               next_state = LOAD;
               addr_next  = '0;
               count_next = '0;
            end
         end
         LOAD: begin
            // The write cycle blocks intake so the packer never overlaps words.
            ready       = !word_valid;
            load_accept = bus.byte_valid_i && !word_valid;
            if (word_valid) begin
               we         = 1'b1;
               data       = word;
               addr_next  = addr + ADDR_W'(1);
               count_next = count + (ADDR_W + 1)'(1);
               if (word == HALT_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                  next_state = CSUM;
`else
                  next_state = (addr == LAST_ADDR) ? RUN : FILL;
`endif
               end else if (addr == LAST_ADDR) begin
                  next_state = ERROR;
               end
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            ready = 1'b1;
            if (bus.byte_valid_i) begin
               if (bus.byte_i != csum)       next_state = ERROR;
               else if (count == FULL_COUNT) next_state = RUN;
               else                          next_state = FILL;
            end
         end
`endif
         FILL: begin
            we   = 1'b1;
            data = HALT_WORD;
            if (addr == LAST_ADDR) next_state = RUN;
            else                   addr_next  = addr + ADDR_W'(1);
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         addr      <= '0;
         count     <= '0;
         cpu_rst_n <= 1'b0;
      end else begin
         state     <= next_state;
         addr      <= addr_next;
         count     <= count_next;
         // Released one cycle after RUN is entered; dropped on the restart edge.
         cpu_rst_n <= (state == RUN) && (next_state == RUN);
      end
   end

   assign bus.byte_ready_o = ready;
   assign bus.im_we_o      = we;
   assign bus.im_addr_o    = addr;
   assign bus.im_data_o    = data;
   assign cpu_rst_n_o      = cpu_rst_n;
   assign busy_o           = (state == LOAD) || (state == FILL) || (state == CSUM);
   assign done_o           = (state == RUN);
   assign err_o            = (state == ERROR);
   assign word_count_o     = count;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader with a behavioural IM model.
// Build with LOADER_CHECKSUM_EN to exercise the checksum path as well.
module tb_instr_loader;

   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   localparam logic [31:0] POISON = 32'h0BAD_0BAD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_start = 1'b0;
   logic       cpu_rst_n, busy, done, err;
   logic [5:0] word_count;

   int          checks = 0;
   int          failures = 0;
   int          n_writes = 0;
   logic [31:0] mem [32];
   logic [7:0]  tb_xor;

   instr_loader_if #(.ADDR_W(5)) bus ();

   instr_loader dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .load_start_i (load_start),
      .bus          (bus),
      .cpu_rst_n_o  (cpu_rst_n),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .word_count_o (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Instruction-memory model; the write lands on the posedge ending this cycle.
   always @(negedge clk) begin
      if (bus.im_we_o === 1'b1) begin
         mem[bus.im_addr_o] <= bus.im_data_o;
         n_writes++;
         check("ready_in_write", bus.byte_ready_o, 1'b0);
      end
   end

   task automatic start_load();
      for (int i = 0; i < 32; i++) mem[i] = POISON;
      n_writes   = 0;
      tb_xor     = 8'h00;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_i       = b;
      bus.byte_valid_i = 1'b1;
      while (bus.byte_ready_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.byte_ready_o !== 1'b1) check("ready_timeout", bus.byte_ready_o, 1'b1);
      @(negedge clk);
      tb_xor           = tb_xor ^ b;
      bus.byte_valid_i = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[31-8*i -: 8]);
         if (gap) @(negedge clk);
      end
   endtask

   task automatic send_csum();
      logic [7:0] c;
      c = tb_xor;
      send_byte(c);
   endtask

   task automatic wait_settled();
      int n = 0;
      while (done !== 1'b1 && err !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("settle", done | err, 1'b1);
   endtask

   task automatic check_fill(input int first);
      int bad = 0;
      for (int i = first; i < 32; i++) if (mem[i] !== HALT) bad++;
      check("fill_bad_words", bad, 0);
   endtask

   initial begin
      bus.byte_i       = 8'h00;
      bus.byte_valid_i = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", bus.byte_ready_o, 1'b0);
      check("rst_we", bus.im_we_o, 1'b0);
      check("rst_addr", bus.im_addr_o, 5'd0);
      check("rst_data", bus.im_data_o, 32'h0);
      check("rst_cpu", cpu_rst_n, 1'b0);
      check("rst_flags", {busy, done, err}, 3'b000);
      check("rst_count", word_count, 6'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ignores_valid", bus.byte_ready_o, 1'b0);

      // Basic image: one word plus terminator
      start_load();
      check("t1_busy", busy, 1'b1);
      send_word(32'h0000_0020, 1'b0);
      send_word(HALT, 1'b0);
      check("t1_term_we", bus.im_we_o, 1'b1);
      check("t1_term_addr", bus.im_addr_o, 5'd1);
      check("t1_term_data", bus.im_data_o, HALT);
`ifdef LOADER_CHECKSUM_EN
      send_csum();
      wait_settled();
      repeat (2) @(negedge clk);
`else
      repeat (31) @(negedge clk);
      check("t1_cpu_31", cpu_rst_n, 1'b0);
      check("t1_done_31", done, 1'b1);
      @(negedge clk);
`endif
      check("t1_cpu_run", cpu_rst_n, 1'b1);
      check("t1_mem0", mem[0], 32'h0000_0020);
      check_fill(1);
      check("t1_count", word_count, 6'd2);
      check("t1_writes", n_writes, 32);
      check("t1_err", err, 1'b0);

      // Restart from RUN; 3-word image with byte_valid toggling
      start_load();
      check("t2_done_drop", done, 1'b0);
      check("t2_cpu_drop", cpu_rst_n, 1'b0);
      send_word(32'h0102_0304, 1'b1);
      send_word(32'hDEAD_BEEF, 1'b1);
      send_word(HALT, 1'b1);
`ifdef LOADER_CHECKSUM_EN
      send_csum();
`endif
      wait_settled();
      check("t2_mem0", mem[0], 32'h0102_0304);
      check("t2_mem1", mem[1], 32'hDEAD_BEEF);
      check_fill(2);
      check("t2_count", word_count, 6'd3);
      check("t2_done", done, 1'b1);

      // Overflow: 32 words and no terminator
      start_load();
      for (int i = 0; i < 32; i++) send_word(32'h0102_0300 + i, 1'b0);
      wait_settled();
      repeat (5) @(negedge clk);
      check("t3_writes", n_writes, 32);
      check("t3_mem31", mem[31], 32'h0102_031F);
      check("t3_err", err, 1'b1);
      check("t3_cpu", cpu_rst_n, 1'b0);
      check("t3_done", done, 1'b0);
      check("t3_count", word_count, 6'd32);
      check("t3_ready", bus.byte_ready_o, 1'b0);

      // Reset after 6 bytes, then a fresh image
      start_load();
      check("t4_err_clear", err, 1'b0);
      send_word(32'hAABB_CCDD, 1'b0);
      send_byte(8'h11);
      send_byte(8'h22);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      @(negedge clk);
      check("t4_start_ignored", word_count, 6'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t4_rst_count", word_count, 6'd0);
      check("t4_rst_busy", busy, 1'b0);
      start_load();
      send_word(32'h1357_9BDF, 1'b0);
      send_word(HALT, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      send_csum();
`endif
      wait_settled();
      check("t4_mem0", mem[0], 32'h1357_9BDF);
      check("t4_mem1", mem[1], HALT);
      check("t4_err", err, 1'b0);
      check("t4_done", done, 1'b1);
      check("t4_count", word_count, 6'd2);

      // Terminator as word 31: no pad writes
      start_load();
      for (int i = 0; i < 31; i++) send_word(32'hA000_0000 + i, 1'b0);
      send_word(HALT, 1'b0);
      check("t5_term_we", bus.im_we_o, 1'b1);
      check("t5_term_addr", bus.im_addr_o, 5'd31);
`ifdef LOADER_CHECKSUM_EN
      send_csum();
      wait_settled();
`else
      @(negedge clk);
      check("t5_run_next", {done, busy}, 2'b10);
      check("t5_cpu_first", cpu_rst_n, 1'b0);
      @(negedge clk);
      check("t5_cpu_run", cpu_rst_n, 1'b1);
`endif
      check("t5_writes", n_writes, 32);
      check("t5_mem30", mem[30], 32'hA000_001E);
      check("t5_mem31", mem[31], HALT);
      check("t5_count", word_count, 6'd32);

`ifdef LOADER_CHECKSUM_EN
      // Checksum: XOR of 12 34 56 78 FF FF FF FF is 08
      start_load();
      send_word(32'h1234_5678, 1'b0);
      send_word(HALT, 1'b0);
      send_byte(8'h08);
      wait_settled();
      check("t6_good_done", done, 1'b1);
      check("t6_good_err", err, 1'b0);
      start_load();
      send_word(32'h1234_5678, 1'b0);
      send_word(HALT, 1'b0);
      send_byte(8'h09);
      wait_settled();
      @(negedge clk);
      check("t6_bad_err", err, 1'b1);
      check("t6_bad_cpu", cpu_rst_n, 1'b0);
      check("t6_bad_done", done, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
      $fatal(1);
   end

endmodule
